// File: rtl/tdm_pkg.sv
// Shared constants and types for the TDM line framer/deframer pair.
package tdm_pkg;

   localparam int BITS_PER_TS = 8;
   localparam int C4_PER_BIT  = 2;
   localparam int N_TS_DEF    = 32;

   // c4 rising edges carrying data in one frame (the f0 edge is not counted)
   localparam int FRAME_EDGES = C4_PER_BIT * BITS_PER_TS * N_TS_DEF;

   // One spare bit so the edge counter can rest on FRAME_EDGES, which marks
   // the position where the next frame pulse is expected.
   localparam int K_W = $clog2(FRAME_EDGES) + 1;

   typedef enum logic [0:0] {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } sync_state_t;

   function automatic int frame_edges(input int n_ts);
      return C4_PER_BIT * BITS_PER_TS * n_ts;
   endfunction

endpackage

// File: rtl/tdm_in_sync.sv
// Synchronizer bank for the asynchronous TDM line: two flops per input plus
// a third c4 flop so a c4 rising edge becomes a one-clk enable.
module tdm_in_sync (
   input  logic clk50,
   input  logic reset_n,
   input  logic c4,
   input  logic f0,
   input  logic data_in,
   output logic ce,
   output logic f0_s,
   output logic data_s
);

   logic c4_p0, c4_p1, c4_p2;
   logic f0_p0, f0_p1;
   logic data_p0, data_p1;

   // Metastability flops; f0 rests high so reset never fakes a frame pulse
   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         c4_p0   <= 1'b0;
         c4_p1   <= 1'b0;
         c4_p2   <= 1'b0;
         f0_p0   <= 1'b1;
         f0_p1   <= 1'b1;
         data_p0 <= 1'b0;
         data_p1 <= 1'b0;
      end else begin
         c4_p0   <= c4;
         c4_p1   <= c4_p0;
         c4_p2   <= c4_p1;
         f0_p0   <= f0;
         f0_p1   <= f0_p0;
         data_p0 <= data_in;
         data_p1 <= data_p0;
      end
   end

   assign ce     = c4_p1 & ~c4_p2;
   assign f0_s   = f0_p1;
   assign data_s = data_p1;

endmodule

// File: rtl/tdm_rx_deframer.sv
// Receive deframer: recovers timeslot bytes from the c4/f0/data TDM line,
// keeps frame lock with a flywheel and raises a frame-group interrupt.
module tdm_rx_deframer
   import tdm_pkg::*;
#(
   parameter int N_TS       = 32,
   parameter int INT_DIV    = 8,
   parameter int MISS_LIMIT = 3
) (
   input  logic       clk50,
   input  logic       reset_n,
   input  logic       c4,
   input  logic       f0,
   input  logic       data_in,
   input  logic       irq_ack,
   output logic [7:0] ts_data,
   output logic [4:0] ts_index,
   output logic       ts_valid,
   output logic       frame_start,
   output logic       locked,
   output logic       sync_err,
   output logic       irq
);

   localparam logic [K_W-1:0] K_END = K_W'(frame_edges(N_TS));
   localparam int FC_W = (INT_DIV > 1) ? $clog2(INT_DIV) : 1;
   localparam int MC_W = $clog2(MISS_LIMIT + 1);

   logic            ce, f0_s, data_s;
   sync_state_t     state;
   logic [K_W-1:0]  k;
   logic            f0_low_q;
   logic [6:0]      shreg;
   logic [MC_W-1:0] miss_cnt;
   logic [FC_W-1:0] frame_cnt;
   logic            at_end, first_low, acquire, normal, realign;
   logic            miss, drop, bit_ce, byte_done, count_frame, grp_wrap;

   tdm_in_sync u_in_sync (
      .clk50   (clk50),
      .reset_n (reset_n),
      .c4      (c4),
      .f0      (f0),
      .data_in (data_in),
      .ce      (ce),
      .f0_s    (f0_s),
      .data_s  (data_s)
   );

   // Line events, all qualified by the c4 edge enable. Only the first ce of a
   // run of f0-low edges is a boundary; later lows just hold k at zero.
   assign at_end      = (k == K_END);
   assign first_low   = ce & ~f0_s & ~f0_low_q;
   assign acquire     = first_low & (state == HUNT);
   assign normal      = first_low & (state == LOCKED) & at_end;
   assign realign     = first_low & (state == LOCKED) & ~at_end;
   assign miss        = ce & f0_s & (state == LOCKED) & at_end;
   assign drop        = miss & (miss_cnt == MC_W'(MISS_LIMIT - 1));
   assign bit_ce      = ce & f0_s & ~at_end;
   assign byte_done   = bit_ce & (state == LOCKED) & (k[3:0] == 4'hF);
   assign count_frame = normal | (miss & ~drop);
   assign grp_wrap    = count_frame & (frame_cnt == FC_W'(INT_DIV - 1));
   assign locked      = (state == LOCKED);

   // Lock state and consecutive missing-pulse counter
   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         state    <= HUNT;
         miss_cnt <= '0;
      end else if (acquire || normal) begin
         state    <= LOCKED;
         miss_cnt <= '0;
      end else if (drop) begin
         state    <= HUNT;
         miss_cnt <= '0;
      end else if (miss) begin
         miss_cnt <= miss_cnt + 1'b1;
      end
   end

   // Edge counter: f0 low or a flywheeled boundary restarts the frame; in
   // HUNT it parks at K_END until a frame pulse arrives.
   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         k        <= '0;
         f0_low_q <= 1'b0;
      end else if (ce) begin
         f0_low_q <= ~f0_s;
         if (!f0_s || miss) begin
            k <= '0;
         end else if (!at_end) begin
            k <= k + 1'b1;
         end
      end
   end

   // Bit shifter: sample on odd edges, MSB first; stale bits are fully
   // overwritten before the next byte completes, so no reset is needed.
   always_ff @(posedge clk50) begin
      if (bit_ce && k[0]) begin
         shreg <= {shreg[5:0], data_s};
      end
   end

   // Timeslot output and one-clk line event strobes
   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         ts_data     <= '0;
         ts_index    <= '0;
         ts_valid    <= 1'b0;
         frame_start <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         ts_valid    <= byte_done;
         frame_start <= acquire | normal | (miss & ~drop);
         sync_err    <= realign | miss;
         if (byte_done) begin
            ts_data  <= {shreg, data_s};
            ts_index <= k[8:4];
         end
      end
   end

   // Frame-group counter and interrupt; a set in the same clk as an ack wins
   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt <= '0;
         irq       <= 1'b0;
      end else begin
         if (drop) begin
            frame_cnt <= '0;
         end else if (count_frame) begin
            frame_cnt <= grp_wrap ? '0 : frame_cnt + 1'b1;
         end
         if (grp_wrap) begin
            irq <= 1'b1;
         end else if (irq_ack) begin
            irq <= 1'b0;
         end
      end
   end

endmodule
